button_event_ctrl: RTL and testbench

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl_pkg.sv | 37 +++
 rtl/button_event_ctrl_if.sv | 9 +
 rtl/button_event_ctrl_pb_debounce.sv | 84 ++++++++
 rtl/button_event_ctrl.sv | 66 ++++++
 tb/tb_button_event_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the pushbutton event block: debounce state encoding,
// evt_word bit positions and a helper that packs the event word.
package button_event_ctrl_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } db_state_e;

    localparam int EVT_PEND1_BIT = 0;
    localparam int EVT_PEND2_BIT = 1;
    localparam int EVT_LVL1_BIT  = 2;
    localparam int EVT_LVL2_BIT  = 3;
    localparam int EVT_CNT1_LSB  = 8;
    localparam int EVT_CNT2_LSB  = 16;
    localparam int EVT_CNT_W     = 8;

    function automatic logic [31:0] pack_evt_word(
        input logic [1:0]           pend,
        input logic [1:0]           lvl,
        input logic [EVT_CNT_W-1:0] cnt1,
        input logic [EVT_CNT_W-1:0] cnt2
    );
        logic [31:0] w;
        w                              = '0;
        w[EVT_PEND1_BIT]               = pend[0];
        w[EVT_PEND2_BIT]               = pend[1];
        w[EVT_LVL1_BIT]                = lvl[0];
        w[EVT_LVL2_BIT]                = lvl[1];
        w[EVT_CNT1_LSB +: EVT_CNT_W]   = cnt1;
        w[EVT_CNT2_LSB +: EVT_CNT_W]   = cnt2;
        return w;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Processor-side view of the event block: read strobe in, event word and irq out.
interface button_event_ctrl_if;
    logic        rd_strobe;
    logic [31:0] evt_word;
    logic        evt_irq;

    modport master (output rd_strobe, input evt_word, input evt_irq);
    modport slave  (input rd_strobe, output evt_word, output evt_irq);
endinterface

// File: rtl/button_event_ctrl_pb_debounce.sv
// One pushbutton: 2-flop synchronizer, 4-state debounce FSM with stability
// counter, registered debounced level and a one-cycle press pulse.
module pb_debounce
    import button_event_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic aclr,
    input  logic pb_n,
    output logic level,
    output logic press
);

    // The entry sample counts as the first stable one, so the counter
    // reaching DEBOUNCE_CYCLES-1 marks DEBOUNCE_CYCLES stable samples.
    localparam int               LAST_INT = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

    logic             sync1_reg;
    logic             sync2_reg;
    db_state_e        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            state_reg <= UP;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= pb_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            case (state_reg)
                UP: begin
                    if (!sync2_reg) begin
                        state_reg <= WAIT_DOWN;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_DOWN: begin
                    if (sync2_reg) begin
                        state_reg <= UP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg + 1'b1 == CNT_LAST) begin
                            state_reg <= DOWN;
                            level_reg <= 1'b1;
                            press_reg <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (sync2_reg) begin
                        state_reg <= WAIT_UP;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_UP: begin
                    if (!sync2_reg) begin
                        state_reg <= DOWN;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg + 1'b1 == CNT_LAST) begin
                            state_reg <= UP;
                            level_reg <= 1'b0;
                        end
                    end
                end
                default: state_reg <= UP;
            endcase
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/button_event_ctrl.sv
// Two debounced pushbuttons feeding sticky pending flags, 8-bit press counters
// and a processor-readable event word with an interrupt.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                clock,
    input  logic                aclr,
    input  logic                pb1_n,
    input  logic                pb2_n,
    button_event_ctrl_if.slave  bus
);

    logic [1:0]           pb_raw;
    logic [1:0]           level;
    logic [1:0]           press;
    logic [1:0]           pend_reg;
    logic [1:0]           pend_next;
    logic [EVT_CNT_W-1:0] cnt_reg [2];
    logic                 irq_reg;

    assign pb_raw = {pb2_n, pb1_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pb
            pb_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_db (
                .clock (clock),
                .aclr  (aclr),
                .pb_n  (pb_raw[gi]),
                .level (level[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // A press arriving with the read strobe wins, so no event is dropped.
    assign pend_next = press | (pend_reg & {2{~bus.rd_strobe}});

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            pend_reg <= '0;
            irq_reg  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            pend_reg <= pend_next;
            irq_reg  <= |pend_next;
            for (int i = 0; i < 2; i++) begin
                if (press[i]) begin
                    cnt_reg[i] <= cnt_reg[i] + 8'd1;
                end
            end
        end
    end

    // Every bit of the event word is taken directly from a flop.
    assign bus.evt_word = pack_evt_word(pend_reg, level, cnt_reg[0], cnt_reg[1]);
    assign bus.evt_irq  = irq_reg;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl with DEBOUNCE_CYCLES=4: a scoreboard of expected
// event-word changes plus cycle-exact latency checks.
module tb_button_event_ctrl;

    logic clock;
    logic aclr;
    logic pb1_n;
    logic pb2_n;

    button_event_ctrl_if bus();

    button_event_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clock (clock),
        .aclr  (aclr),
        .pb1_n (pb1_n),
        .pb2_n (pb2_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb [$];
    logic [31:0] prev_word;
    logic [1:0]  m_pend;
    logic [1:0]  m_lvl;
    logic [7:0]  m_cnt [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        return {8'h00, m_cnt[1], m_cnt[0], 4'h0, m_lvl[1], m_lvl[0], m_pend[1], m_pend[0]};
    endfunction

    function automatic logic [31:0] lvl_bit(input int b);
        return 32'(bus.evt_word[2 + b]);
    endfunction

    function automatic logic [31:0] pend_bit(input int b);
        return 32'(bus.evt_word[b]);
    endfunction

    function automatic logic [31:0] cnt_field(input int b);
        return (b == 0) ? 32'(bus.evt_word[15:8]) : 32'(bus.evt_word[23:16]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_pb(input int b, input logic v);
        if (b == 0) pb1_n = v;
        else        pb2_n = v;
    endtask

    task automatic model_reset();
        m_pend   = '0;
        m_lvl    = '0;
        m_cnt[0] = '0;
        m_cnt[1] = '0;
    endtask

    // Scoreboard monitor: every change of evt_word must match the next expected word.
    always @(negedge clock) begin
        if (!aclr) begin
            prev_word = bus.evt_word;
        end else if (bus.evt_word !== prev_word) begin
            if (sb.size() == 0) begin
                check_val("sb_spurious", bus.evt_word, prev_word);
            end else begin
                logic [31:0] want_word;
                want_word = sb.pop_front();
                check_val("sb_word", bus.evt_word, want_word);
                check_val("sb_irq", 32'(bus.evt_irq), 32'(|want_word[1:0]));
            end
            prev_word = bus.evt_word;
        end
    end

    task automatic press(input int b, input bit rd_mid);
        set_pb(b, 1'b0);
        m_lvl[b] = 1'b1;
        sb.push_back(model_word());
        if (rd_mid) m_pend = '0;
        m_pend[b] = 1'b1;
        m_cnt[b]  = m_cnt[b] + 8'd1;
        sb.push_back(model_word());
        tick(5);
        check_val("lvl_early", lvl_bit(b), 32'd0);
        tick(1);
        check_val("lvl_on_time", lvl_bit(b), 32'd1);
        if (rd_mid) bus.rd_strobe = 1'b1;
        tick(1);
        bus.rd_strobe = 1'b0;
        check_val("press_pend", pend_bit(b), 32'd1);
        check_val("press_cnt", cnt_field(b), 32'(m_cnt[b]));
        $display("press pb%0d rd=%0d word=%08h", b + 1, rd_mid, bus.evt_word);
        tick(2);
    endtask

    task automatic release_pb(input int b);
        set_pb(b, 1'b1);
        m_lvl[b] = 1'b0;
        sb.push_back(model_word());
        tick(5);
        check_val("rel_lvl_early", lvl_bit(b), 32'd1);
        tick(1);
        check_val("rel_lvl_on_time", lvl_bit(b), 32'd0);
        tick(2);
    endtask

    task automatic rd_pulse();
        if (m_pend != 2'b00) begin
            m_pend = '0;
            sb.push_back(model_word());
        end
        bus.rd_strobe = 1'b1;
        tick(1);
        bus.rd_strobe = 1'b0;
        check_val("rd_pend", 32'(bus.evt_word[1:0]), 32'd0);
        check_val("rd_irq", 32'(bus.evt_irq), 32'd0);
        $display("read word=%08h", bus.evt_word);
    endtask

    initial begin
        aclr = 1'b0;
        pb1_n = 1'b1;
        pb2_n = 1'b1;
        bus.rd_strobe = 1'b0;
        prev_word = '0;
        model_reset();
        tick(3);
        check_val("reset_word", bus.evt_word, 32'd0);
        check_val("reset_irq", 32'(bus.evt_irq), 32'd0);
        aclr = 1'b1;
        tick(2);

        // Short bounces never last long enough to be accepted.
        for (int i = 0; i < 3; i++) begin
            pb1_n = 1'b0;
            tick(2);
            pb1_n = 1'b1;
            tick(4);
        end
        tick(6);
        check_val("bounce_word", bus.evt_word, 32'd0);
        check_val("bounce_irq", 32'(bus.evt_irq), 32'd0);

        press(0, 1'b0);
        check_val("irq_after_press", 32'(bus.evt_irq), 32'd1);
        release_pb(0);
        rd_pulse();

        press(1, 1'b0);
        rd_pulse();
        check_val("rd_keeps_cnt2", cnt_field(1), 32'(m_cnt[1]));
        check_val("rd_keeps_lvl2", lvl_bit(1), 32'd1);
        release_pb(1);

        press(0, 1'b1);
        release_pb(0);

        // Both buttons at once: levels rise together, then both pending bits.
        pb1_n = 1'b0;
        pb2_n = 1'b0;
        m_lvl = 2'b11;
        sb.push_back(model_word());
        m_pend = 2'b11;
        m_cnt[0] = m_cnt[0] + 8'd1;
        m_cnt[1] = m_cnt[1] + 8'd1;
        sb.push_back(model_word());
        tick(7);
        check_val("both_pend", 32'(bus.evt_word[1:0]), 32'd3);
        $display("press both word=%08h", bus.evt_word);
        pb1_n = 1'b1;
        pb2_n = 1'b1;
        m_lvl = 2'b00;
        sb.push_back(model_word());
        tick(8);
        rd_pulse();

        // Reset in the middle of WAIT_DOWN with pb2 held low.
        pb2_n = 1'b0;
        tick(4);
        aclr = 1'b0;
        #1;
        check_val("midreset_word", bus.evt_word, 32'd0);
        check_val("midreset_irq", 32'(bus.evt_irq), 32'd0);
        model_reset();
        tick(2);
        m_lvl[1] = 1'b1;
        sb.push_back(model_word());
        m_pend[1] = 1'b1;
        m_cnt[1]  = 8'd1;
        sb.push_back(model_word());
        aclr = 1'b1;
        tick(5);
        check_val("post_reset_lvl_early", lvl_bit(1), 32'd0);
        tick(1);
        check_val("post_reset_lvl", lvl_bit(1), 32'd1);
        tick(1);
        check_val("post_reset_cnt", cnt_field(1), 32'd1);
        $display("press after reset word=%08h", bus.evt_word);
        tick(2);
        release_pb(1);
        rd_pulse();

        // 256 presses bring the PB1 count back round to zero.
        for (int i = 0; i < 256; i++) begin
            press(0, 1'b0);
            release_pb(0);
        end
        check_val("cnt_wrap", cnt_field(0), 32'd0);

        tick(4);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
